// File: rtl/apb_master.sv
// apb_master: turns single local commands into APB SETUP/ACCESS transfers
// and returns one completion per command. Handles wait states, slave errors
// and an ACCESS-phase timeout. One transfer in flight at a time.
module apb_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  p_clk,
  input  logic                  p_reset,
  // local command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // completion port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB requester port
  output logic                  p_sel,
  output logic                  p_enable,
  output logic                  p_write,
  output logic [ADDR_WIDTH-1:0] p_addr,
  output logic [DATA_WIDTH-1:0] p_wdata,
  input  logic                  p_ready,
  input  logic [DATA_WIDTH-1:0] p_rdata,
  input  logic                  p_slverr
);

  // Counter is kept at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          cmd_fire;
  logic          timeout_hit;

  assign cmd_fire    = cmd_valid && cmd_ready;
  // A ready slave always wins over the timeout on the last allowed cycle.
  assign timeout_hit = (TIMEOUT != 0) && !p_ready && (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge p_clk) begin
    if (p_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and Moore-decoded control outputs.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    p_sel     = 1'b0;
    p_enable  = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !p_reset;
        if (cmd_fire) state_nxt = SETUP;
      end
      SETUP: begin
        p_sel     = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        p_sel    = 1'b1;
        p_enable = 1'b1;
        if (p_ready || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, wait counter and completion capture.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      p_write     <= 1'b0;
      p_addr      <= '0;
      p_wdata     <= '0;
      cnt         <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            p_write <= cmd_write;
            p_addr  <= cmd_addr;
            p_wdata <= cmd_wdata;
            cnt     <= '0;
          end
        end
        ACCESS: begin
          if (p_ready) begin
            rsp_rdata   <= p_write ? '0 : p_rdata;
            rsp_err     <= p_slverr;
            rsp_timeout <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with TIMEOUT=4.
module tb_apb_master;

  logic        p_clk = 1'b0;
  logic        p_reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        p_sel, p_enable, p_write, p_ready, p_slverr;
  logic [31:0] p_addr, p_wdata, p_rdata;

  int passed = 0;
  int total  = 0;
  int acc_cycles;

  apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .p_clk(p_clk), .p_reset(p_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write),
    .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ready(p_ready), .p_rdata(p_rdata), .p_slverr(p_slverr)
  );

  always #5 p_clk = ~p_clk;

  task automatic tick();
    @(posedge p_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a command and clock the handshake; returns with SETUP visible.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    p_reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; p_ready = 0; p_rdata = 0; p_slverr = 0;

    // reset state
    tick(); tick();
    chk("rst_sel", {31'd0, p_sel}, 0);
    chk("rst_en", {31'd0, p_enable}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    chk("rst_addr", p_addr, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", {30'd0, rsp_err, rsp_timeout}, 0);
    p_reset = 1'b0;
    #1;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 1);

    // zero-wait write
    p_ready = 1; rsp_ready = 1;
    issue(1'b1, 32'h10, 32'hA5A5_0001);
    chk("zw_setup", {30'd0, p_sel, p_enable}, 32'b10);
    chk("zw_cmd_ready", {31'd0, cmd_ready}, 0);
    tick();
    chk("zw_access", {30'd0, p_sel, p_enable}, 32'b11);
    chk("zw_addr", p_addr, 32'h10);
    chk("zw_wdata", p_wdata, 32'hA5A5_0001);
    chk("zw_write", {31'd0, p_write}, 1);
    tick();
    chk("zw_rsp", {29'd0, rsp_valid, p_sel, rsp_err}, 32'b100);
    chk("zw_rdata", rsp_rdata, 0);
    tick();
    chk("zw_idle", {31'd0, cmd_ready}, 1);

    // read with 2 wait states; slverr while not ready must be ignored
    p_ready = 0; p_slverr = 1;
    issue(1'b0, 32'h24, 32'h0);
    tick();
    chk("rd_acc1", {30'd0, p_sel, p_enable}, 32'b11);
    tick();
    chk("rd_acc2", {30'd0, p_sel, p_enable}, 32'b11);
    tick();
    chk("rd_acc3", {30'd0, p_sel, p_enable}, 32'b11);
    chk("rd_addr", p_addr, 32'h24);
    p_ready = 1; p_slverr = 0; p_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rd_rsp_valid", {31'd0, rsp_valid}, 1);
    chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_err", {30'd0, rsp_err, rsp_timeout}, 0);
    tick();

    // slave error on a write
    p_slverr = 1; p_rdata = 32'h1111_2222;
    issue(1'b1, 32'h40, 32'h5);
    tick(); tick();
    chk("se_err", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'b110);
    chk("se_rdata", rsp_rdata, 0);
    p_slverr = 0;
    tick();

    // timeout: p_ready never asserts
    p_ready = 0;
    issue(1'b0, 32'h50, 32'h0);
    acc_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (p_enable) acc_cycles++;
      else break;
    end
    chk("to_access_cycles", acc_cycles, 4);
    chk("to_flags", {28'd0, rsp_valid, p_sel, rsp_err, rsp_timeout}, 32'b1011);
    chk("to_rdata", rsp_rdata, 0);
    tick();

    // p_ready on the final timeout cycle completes normally
    issue(1'b0, 32'h54, 32'h0);
    tick(); tick(); tick(); tick();
    chk("tb_acc4", {30'd0, p_sel, p_enable}, 32'b11);
    p_ready = 1; p_rdata = 32'h0000_1234;
    tick();
    chk("tb_flags", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'b100);
    chk("tb_rdata", rsp_rdata, 32'h0000_1234);
    tick();

    // backpressure with a second command waiting
    rsp_ready = 0; p_rdata = 32'h0000_0055;
    issue(1'b0, 32'h60, 32'h0);
    tick(); tick();
    cmd_write = 1; cmd_addr = 32'h30; cmd_wdata = 32'h7777_0000; cmd_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {29'd0, rsp_valid, cmd_ready, rsp_err}, 32'b100);
      chk("bp_rdata", rsp_rdata, 32'h0000_0055);
      p_rdata = 32'hFFFF_FFFF;
      tick();
    end
    rsp_ready = 1;
    tick();
    chk("bp_idle_accept", {30'd0, cmd_ready, rsp_valid}, 32'b10);
    tick();
    cmd_valid = 0;
    chk("bp_second_setup", {30'd0, p_sel, p_enable}, 32'b10);
    chk("bp_second_addr", p_addr, 32'h30);
    tick(); tick();
    chk("bp_second_rsp", {31'd0, rsp_valid}, 1);
    tick();

    // reset in the 2nd wait cycle of ACCESS
    p_ready = 0;
    issue(1'b0, 32'h70, 32'h0);
    tick(); tick();
    chk("mr_in_wait", {30'd0, p_sel, p_enable}, 32'b11);
    p_reset = 1;
    tick();
    chk("mr_released", {29'd0, p_sel, p_enable, rsp_valid}, 0);
    chk("mr_rdata", rsp_rdata, 0);
    p_reset = 0;
    #1;
    chk("mr_idle", {31'd0, cmd_ready}, 1);
    p_ready = 1; p_rdata = 32'hCAFE_F00D;
    issue(1'b0, 32'h74, 32'h0);
    tick(); tick();
    chk("mr_new_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'b100);
    chk("mr_new_rdata", rsp_rdata, 32'hCAFE_F00D);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that converts single transfers from a local command port into APB SETUP/ACCESS sequences and returns a completion on a response port. It drives the slave-side APB port of blocks such as the APB-SSI register front end. It handles one transfer at a time, supports slave wait states through `p_ready`, reports `p_slverr`, and aborts ACCESS phases that run too long.

## Interface
- `DATA_WIDTH`, 32, APB and command data width.
- `ADDR_WIDTH`, 32, APB and command address width.
- `TIMEOUT`, 16, maximum number of ACCESS cycles before abort. Value 0 disables the timeout.

- `p_clk`  in  1  sole clock; all logic is on the rising edge.
- `p_reset`  in  1  reset, synchronous and active-high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accept; a command transfers when `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  transfer address.
- `cmd_wdata`  in  DATA_WIDTH  write data.
- `rsp_valid`  out  1  completion available.
- `rsp_ready`  in  1  completion accept.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- `rsp_err`  out  1  completion error (slave error or timeout).
- `rsp_timeout`  out  1  error was caused by the timeout.
- `p_sel`, `p_enable`, `p_write`  out  1  APB control.
- `p_addr`  out  ADDR_WIDTH  APB address.
- `p_wdata`  out  DATA_WIDTH  APB write data.
- `p_ready`  in  1  slave ready.
- `p_rdata`  in  DATA_WIDTH  slave read data.
- `p_slverr`  in  1  slave error, sampled only with `p_ready`.

## Operation
- State machine states: IDLE, SETUP, ACCESS, RESP. The machine is Moore; APB control is decoded from registered state.
- **IDLE:** `cmd_ready`=1, gated low while `p_reset`=1.
  - On handshake: latch `cmd_write`/`cmd_addr`/`cmd_wdata` into `p_write`/`p_addr`/`p_wdata`, then go to SETUP.
- **SETUP:** `p_sel`=1, `p_enable`=0 for exactly one cycle, then go to ACCESS unconditionally.
- **ACCESS:** `p_sel`=1, `p_enable`=1.
  - If `p_ready`=1: capture `rsp_rdata` = `p_rdata` for reads or 0 for writes, set `rsp_err` = `p_slverr`, set `rsp_timeout` = 0, then go to RESP.
  - Otherwise increment the wait counter, which is `$clog2(TIMEOUT+1)` bits wide and cleared on entry to SETUP.
- **Timeout:** if `TIMEOUT`≠0, `p_ready`=0, and the counter equals `TIMEOUT-1`, go to RESP with `rsp_err`=1, `rsp_timeout`=1, and `rsp_rdata`=0.
- **RESP:** `p_sel`=`p_enable`=0 and `rsp_valid`=1. Response fields stay stable until `rsp_ready`; on `rsp_ready`, go to IDLE.
- `p_addr`, `p_wdata`, and `p_write` stay stable from SETUP through the end of ACCESS, and hold their last values in IDLE/RESP.
- `cmd_ready`=0 in SETUP, ACCESS, and RESP; commands presented then wait (no buffering).
- Only one transfer is outstanding at a time; there is no pipelining of SETUP with the previous ACCESS.

## Timing
- **Reset values:** state IDLE; `p_sel`, `p_enable`, `p_write`, `p_addr`, `p_wdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout`, and the counter are all 0.
- **Reset mid-operation:** at the first rising edge with `p_reset`=1, the bus is released (`p_sel`/`p_enable`=0) and any pending response is discarded. No completion is produced for the aborted transfer.
- **Latency:** with the handshake at edge 0, SETUP is visible in cycle 1 and ACCESS in cycle 2.
  - With `p_ready`=1 in cycle 2, `rsp_valid` is seen in cycle 3.
  - Each wait state adds one cycle.
  - Minimum issue interval is 4 cycles with `rsp_ready` held high.
- **Timeout:** ACCESS lasts at most `TIMEOUT` cycles.
- **`p_ready` on the final timeout cycle:** if `p_ready`=1 in that cycle, the transfer completes normally and no timeout is flagged.
- **Signals outside ACCESS:** `p_ready`, `p_slverr`, and `p_rdata` are ignored.
- **`rsp_ready` outside RESP:** ignored; `rsp_ready` held high does not skip RESP, which always lasts at least one cycle.

## Test plan
- **Zero-wait write:** write `addr`=0x10, `wdata`=0xA5A5_0001, `p_ready` tied 1 → SETUP in cycle 1, ACCESS in cycle 2 with stable `addr`/`data`; `rsp_valid` in cycle 3 with `rsp_err`=0 and `rsp_rdata`=0.
- **Read with 2 wait states:** read `addr`=0x24, `p_ready` low for 2 ACCESS cycles then high with `p_rdata`=0xDEAD_BEEF → ACCESS lasts 3 cycles and `rsp_rdata`=0xDEAD_BEEF.
- **Slave error:** `p_slverr`=1 with `p_ready` → `rsp_err`=1, `rsp_timeout`=0. `p_slverr`=1 while `p_ready`=0 is ignored.
- **Timeout (`TIMEOUT`=4):**
  - `p_ready` never asserts → exactly 4 ACCESS cycles, then `p_sel`=0, `rsp_err`=1, `rsp_timeout`=1.
  - Repeat with `p_ready`=1 on the 4th ACCESS cycle → normal completion.
- **Backpressure:** `rsp_ready`=0 for 5 cycles while a second `cmd_valid` is held → response fields stable and `cmd_ready`=0 throughout; the second command is accepted the cycle after the `rsp_ready` handshake.
- **Reset mid-ACCESS:** assert `p_reset` in the 2nd wait cycle → next edge gives `p_sel`=`p_enable`=`rsp_valid`=0 and state IDLE. After reset deasserts, a new read completes normally.
